fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction fetch sequencer: walks a program ROM, latches one instruction at
// a time into an instruction register and presents it for decode/execute.
// Each instruction takes a FETCH cycle followed by at least one ISSUE cycle.
// A HALT_OP opcode in ISSUE stops the sequencer until reset.
//
// Ports
//   Clk          : single clock, all state changes on the rising edge
//   Rst          : synchronous, active-high reset
//   Run          : start request, only looked at while idle
//   Stall        : downstream not ready, holds the current instruction in ISSUE
//   BranchTaken  : redirect the PC to BranchTarget, only looked at in ISSUE
//   BranchTarget : redirect address
//   DataOp/Datars/Datart/Datard/Datai : ROM fields for address Addr
//   Addr         : ROM address, driven straight from the PC register
//   IrOp/IrRs/IrRt/IrRd/IrImm         : registered instruction fields
//   IrValid      : IR holds an instruction for decode/execute (ISSUE only)
//   PcNext       : address of the instruction following the one in IR
//   Halted       : sequencer stopped on HALT_OP
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Run,
  input  logic       Stall,
  input  logic       BranchTaken,
  input  logic [7:0] BranchTarget,
  input  logic [3:0] DataOp,
  input  logic [2:0] Datars,
  input  logic [2:0] Datart,
  input  logic [2:0] Datard,
  input  logic [7:0] Datai,
  output logic [7:0] Addr,
  output logic [3:0] IrOp,
  output logic [2:0] IrRs,
  output logic [2:0] IrRt,
  output logic [2:0] IrRd,
  output logic [7:0] IrImm,
  output logic       IrValid,
  output logic [7:0] PcNext,
  output logic       Halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  logic [1:0] state_q,    state_d;
  logic [7:0] pc_q,       pc_d;
  logic [3:0] ir_op_q,    ir_op_d;
  logic [2:0] ir_rs_q,    ir_rs_d;
  logic [2:0] ir_rt_q,    ir_rt_d;
  logic [2:0] ir_rd_q,    ir_rd_d;
  logic [7:0] ir_imm_q,   ir_imm_d;
  logic [7:0] pc_next_q,  pc_next_d;
  logic       ir_valid_q, ir_valid_d;
  logic       halted_q,   halted_d;

  // Next-state logic: sequencing, IR capture and PC update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_op_d   = ir_op_q;
    ir_rs_d   = ir_rs_q;
    ir_rt_d   = ir_rt_q;
    ir_rd_d   = ir_rd_q;
    ir_imm_d  = ir_imm_q;
    pc_next_d = pc_next_q;

    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FETCH: begin
        // PC advances here so that ISSUE already sees the sequential address;
        // the 8-bit add wraps FF -> 00 naturally.
        ir_op_d   = DataOp;
        ir_rs_d   = Datars;
        ir_rt_d   = Datart;
        ir_rd_d   = Datard;
        ir_imm_d  = Datai;
        pc_d      = pc_q + 8'd1;
        pc_next_d = pc_q + 8'd1;
        state_d   = ST_ISSUE;
      end

      ST_ISSUE: begin
        // Priority: Stall, then halt opcode, then branch, then sequential.
        if (Stall) begin
          state_d = ST_ISSUE;
        end else if (ir_op_q == HALT_OP) begin
          state_d = ST_HALT;
        end else if (BranchTaken) begin
          pc_d    = BranchTarget;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered and follow the state being entered.
    ir_valid_d = (state_d == ST_ISSUE);
    halted_d   = (state_d == ST_HALT);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_op_q    <= 4'd0;
      ir_rs_q    <= 3'd0;
      ir_rt_q    <= 3'd0;
      ir_rd_q    <= 3'd0;
      ir_imm_q   <= 8'd0;
      pc_next_q  <= 8'd0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_op_q    <= ir_op_d;
      ir_rs_q    <= ir_rs_d;
      ir_rt_q    <= ir_rt_d;
      ir_rd_q    <= ir_rd_d;
      ir_imm_q   <= ir_imm_d;
      pc_next_q  <= pc_next_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign Addr    = pc_q;
  assign IrOp    = ir_op_q;
  assign IrRs    = ir_rs_q;
  assign IrRt    = ir_rt_q;
  assign IrRd    = ir_rd_q;
  assign IrImm   = ir_imm_q;
  assign PcNext  = pc_next_q;
  assign IrValid = ir_valid_q;
  assign Halted  = halted_q;

endmodule
